// File: rtl/warp_mem_responder.sv
// warp_mem_responder
//   Slave end of the warp memory interface. Accepts one warp-wide request,
//   services it against a local word-addressed SRAM model, and returns a
//   warp-wide response LATENCY cycles after acceptance.
// Parameters: THREADS_PER_WARP (lanes, <= 32), MEM_WORDS (power of two),
//   LATENCY (1..255 cycles from accept to response_valid).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   warp_id           issuing warp, captured on accept (internal only)
//   thread_mask       active lanes
//   address           per-lane byte address (bits [1:0] ignored)
//   write_data        per-lane store data
//   write_en          1 = store, 0 = load
//   request_valid     request present; accepted when ready is high
//   read_data         per-lane load data, valid with response_valid
//   ready             can accept a request this cycle
//   response_valid    one-cycle response pulse
//   err_oob           pulses with response_valid if an active lane was out of range
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag out-of-range lanes
//   (dropped stores, 32'hDEAD_BEEF loads, err_oob). Otherwise addresses wrap.
module warp_mem_responder #(
  parameter int THREADS_PER_WARP = 32,
  parameter int MEM_WORDS        = 4096,
  parameter int LATENCY          = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [5:0]                          warp_id,
  input  logic [31:0]                         thread_mask,
  input  logic [THREADS_PER_WARP-1:0][31:0]   address,
  input  logic [THREADS_PER_WARP-1:0][31:0]   write_data,
  input  logic                                write_en,
  input  logic                                request_valid,
  output logic [THREADS_PER_WARP-1:0][31:0]   read_data,
  output logic                                ready,
  output logic                                response_valid,
  output logic                                err_oob
);

  localparam int unsigned TPW = THREADS_PER_WARP;
  localparam int unsigned AW  = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 state_q;
  logic [7:0]             cnt_q;
  logic [TPW-1:0][31:0]   hold_q;
  logic [TPW-1:0][31:0]   read_data_q;
  logic                   ready_q;
  logic                   resp_q;
  logic                   err_pend_q;
  logic                   err_q;
  logic [5:0]             warp_id_q;

  logic [31:0]            mem [MEM_WORDS];

  logic [AW-1:0]          idx [TPW];
  logic [TPW-1:0]         oob;
  logic [TPW-1:0]         lane_en;
  logic [TPW-1:0][31:0]   load_d;
  logic                   any_oob;
  logic                   accept;
  logic                   unused_bits;

  // rst_n gate keeps a request presented during reset from writing the array.
  assign accept = request_valid && ready_q && rst_n;

  always_comb begin
    load_d      = '0;
    oob         = '0;
    lane_en     = '0;
    unused_bits = ^warp_id_q;
    for (int unsigned i = 0; i < TPW; i++) begin
      idx[i]      = address[i][2 +: AW];
      lane_en[i]  = thread_mask[i];
      unused_bits = unused_bits ^ (^address[i][1:0]);
`ifdef MEM_BOUNDS_CHECK_EN
      oob[i] = |address[i][31:AW+2];
`else
      unused_bits = unused_bits ^ (^address[i][31:AW+2]);
`endif
      if (lane_en[i]) begin
        load_d[i] = oob[i] ? 32'hDEAD_BEEF : mem[idx[i]];
      end
    end
    any_oob = |(lane_en & oob);
  end

  // Later loop iterations win, so the highest-numbered lane owns a shared word.
  always_ff @(posedge clk) begin
    if (accept && write_en) begin
      for (int unsigned i = 0; i < TPW; i++) begin
        if (lane_en[i] && !oob[i]) begin
          mem[idx[i]] <= write_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b1;
      resp_q      <= 1'b0;
      err_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      warp_id_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_q <= 1'b0;
          err_q  <= 1'b0;
          if (accept) begin
            warp_id_q  <= warp_id;
            hold_q     <= write_en ? '0 : load_d;
            err_pend_q <= any_oob;
            cnt_q      <= 8'(LATENCY - 1);
            ready_q    <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        // Counter starts at LATENCY-1, so RESP is entered exactly LATENCY
        // edges after accept; with LATENCY=1 the response edge is the next one.
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            resp_q      <= 1'b1;
            read_data_q <= hold_q;
            err_q       <= err_pend_q;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RESP: begin
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign read_data      = read_data_q;
  assign ready          = ready_q;
  assign response_valid = resp_q;
`ifdef MEM_BOUNDS_CHECK_EN
  assign err_oob        = err_q;
`else
  assign err_oob        = 1'b0;
`endif

endmodule
